toll_billing: RTL and testbench
===============================

Name: toll_billing

Overview:
- Downstream stage of the toll-booth lane controller.
- Consumes the lane controller's vehicle-class code (`automovel`) and its charge level (`cobrar`).
- Charges exactly once per vehicle from a per-class fare table. Accumulates revenue and counts vehicles and invalid-class events.
- Shows a switch-selected total on HEX3..HEX0 through a sequential binary-to-BCD converter.

Parameters:
- FARE_C1, 5, fare for class code 4'b1000 (car)
- FARE_C2, 10, fare for class code 4'b1100
- FARE_C3, 15, fare for class code 4'b1110
- FARE_C4, 20, fare for class code 4'b1111
- SAT_MAX, 9999, saturation limit of every accumulator (4 decimal digits)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- automovel  in  4  class code from lane controller, thermometer-coded, valid while cobrar=1
- cobrar  in  1  charge request level from lane controller, high from charge decision until vehicle clears
- clear  in  1  level; zeroes all totals while high
- disp_sel  in  2  display source: 00 revenue, 01 vehicle count, 10 last fare, 11 error count
- HEX3  out  [0:6]  thousands digit, active-low segments a..g
- HEX2  out  [0:6]  hundreds digit
- HEX1  out  [0:6]  tens digit
- HEX0  out  [0:6]  units digit
- LEDR_err  out  1  high while error count is nonzero
- busy  out  1  high while a BCD conversion is in progress

Behaviour:
- All registers use one clock; reset is synchronous and active-high and takes priority over everything.
- Reset values:
  - revenue, vehicle count, error count and last fare are 0.
  - `cobrar_d` is 1.
  - HEX3..HEX0 are 7'b1111111 (blank).
  - LEDR_err is 0 and busy is 0.
  - conversion-pending flag is 1.
- Charge event: `charge = cobrar & ~cobrar_d`, with `cobrar_d` registered each cycle.
  - Because `cobrar_d` resets to 1, a `cobrar` already high at reset release never charges. A low must be seen first.
  - A level held high for any length charges exactly once.
- On a charge with a valid code (1000, 1100, 1110, 1111):
  - revenue += fare, saturating at SAT_MAX;
  - vehicle count += 1, saturating at SAT_MAX;
  - last fare = fare.
  - All three update on the same edge, one cycle after `cobrar` rises.
- On a charge with any other code: error count += 1 (saturating at SAT_MAX); revenue, vehicle count and last fare are unchanged.
- `clear` high:
  - revenue, vehicle count, error count and last fare are forced to 0 on every edge;
  - charge events in those cycles are discarded;
  - `cobrar_d` keeps tracking, so a level rising during `clear` does not charge after `clear` drops.
- Arithmetic: accumulators are 14-bit unsigned. Saturation is tested as `sum > SAT_MAX` before the write, so the value never wraps.
- Display FSM states: IDLE, CONV, LATCH.
  - IDLE: if pending=1, snapshot the selected value, clear pending, go to CONV.
  - CONV: the sub-module runs 14 shift/add-3 iterations, one per cycle; busy=1.
  - LATCH: write HEX3..HEX0 atomically from the BCD result, then go to IDLE.
  - Pending is set on any change of the selected value or of `disp_sel`, including during CONV. A mid-conversion change never aborts the run; it restarts after LATCH.
  - Latency from value change to HEX update: 17 cycles when idle, at most 33 cycles when a change lands mid-conversion.
- Segment encoding: active-low, bit 0 = a … bit 6 = g, e.g. '0' = 7'b0000001.
  - Leading zeros are blanked (7'b1111111); the units digit is always shown.
  - HEX outputs hold their previous value while busy.
- LEDR_err is registered from (error count != 0), so it has one cycle of latency.

Decomposition:
- Shared package `toll_pkg` holds:
  - class-code constants CLS_C1..CLS_C4;
  - default fares;
  - SAT_MAX;
  - disp_sel encodings DSP_REV, DSP_CNT, DSP_FARE, DSP_ERR;
  - display FSM state encodings;
  - the 7-segment digit pattern table and the blank constant.
- One sub-module, `bin2bcd_seq`: 14-bit binary in, 4×4-bit BCD out, start/busy/done handshake, fixed 14-cycle double-dabble.
- Fare lookup, accumulators and segment decode stay in `toll_billing`.

Test Plan:
- Reset, then idle with disp_sel=00 → HEX3..HEX1 blank and HEX0 = '0' pattern (7'b0000001) within 17 cycles; busy seen high for 14 cycles.
- cobrar rises with automovel=1100 and is held 20 cycles → revenue=10, count=1; a second pulse with 1111 → revenue=30, count=2, and disp_sel=00 shows "  30".
- cobrar rises with automovel=0100 → error count=1, LEDR_err=1 one cycle later, revenue unchanged; disp_sel=11 shows "   1".
- Preload revenue to 9995, then charge class 1111 (fare 20) → revenue=9999; a further charge stays at 9999 with no wrap.
- cobrar held high through reset release → no charge; after cobrar falls and rises again → exactly one charge.
- clear high for 3 cycles during a cobrar rising edge → all totals 0 and no charge after clear drops; toggling disp_sel mid-conversion → final HEX shows the newest source within 33 cycles.

Source files
------------

// File: rtl/toll_pkg.sv
// Shared constants, types and helpers for the toll billing stage:
// class codes, default fares, display selects, display FSM states and 7-segment patterns.
package toll_pkg;

    localparam logic [3:0] CLS_C1 = 4'b1000;
    localparam logic [3:0] CLS_C2 = 4'b1100;
    localparam logic [3:0] CLS_C3 = 4'b1110;
    localparam logic [3:0] CLS_C4 = 4'b1111;

    localparam logic [13:0] FARE_C1_DEF = 14'd5;
    localparam logic [13:0] FARE_C2_DEF = 14'd10;
    localparam logic [13:0] FARE_C3_DEF = 14'd15;
    localparam logic [13:0] FARE_C4_DEF = 14'd20;
    localparam logic [13:0] SAT_MAX_DEF = 14'd9999;

    localparam logic [1:0] DSP_REV  = 2'b00;
    localparam logic [1:0] DSP_CNT  = 2'b01;
    localparam logic [1:0] DSP_FARE = 2'b10;
    localparam logic [1:0] DSP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StConv  = 2'd1,
        StLatch = 2'd2
    } disp_state_e;

    // Segments a..g map to indices 0..6; a zero bit lights the segment.
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    function automatic logic [0:6] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One extra bit on the sum lets the limit test happen before any wrap.
    function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [13:0] b,
                                            input logic [13:0] lim);
        logic [14:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) return lim;
        return s[13:0];
    endfunction

endpackage

// File: rtl/toll_billing_if.sv
// Lane-side signal bundle of the toll billing stage: charge inputs, display select and
// the 7-segment / status outputs.
interface toll_billing_if;
    logic [3:0] automovel;
    logic       cobrar;
    logic       clear;
    logic [1:0] disp_sel;
    logic [0:6] HEX3;
    logic [0:6] HEX2;
    logic [0:6] HEX1;
    logic [0:6] HEX0;
    logic       LEDR_err;
    logic       busy;

    modport master (
        output automovel, cobrar, clear, disp_sel,
        input  HEX3, HEX2, HEX1, HEX0, LEDR_err, busy
    );

    modport slave (
        input  automovel, cobrar, clear, disp_sel,
        output HEX3, HEX2, HEX1, HEX0, LEDR_err, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 14-bit value into four BCD digits, one
// shift/add-3 step per cycle, 14 cycles per conversion.
module bin2bcd_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o
);
    localparam logic [3:0] NumIter = 4'd14;

    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [15:0] adj;
    logic [29:0] shifted;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bin_q} << 1;

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i && !busy_q) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = NumIter;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d  = shifted[29:14];
            bin_d  = shifted[13:0];
            cnt_d  = cnt_q - 4'd1;
            busy_d = (cnt_q != 4'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == 4'd1);
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/toll_billing.sv
// Toll billing stage: charges once per vehicle from the fare table, keeps saturating
// totals, and shows a switch-selected total on four blank-suppressed 7-segment digits.
module toll_billing
    import toll_pkg::*;
#(
    parameter logic [13:0] FARE_C1 = FARE_C1_DEF,
    parameter logic [13:0] FARE_C2 = FARE_C2_DEF,
    parameter logic [13:0] FARE_C3 = FARE_C3_DEF,
    parameter logic [13:0] FARE_C4 = FARE_C4_DEF,
    parameter logic [13:0] SAT_MAX = SAT_MAX_DEF
) (
    input logic           clock,
    input logic           reset,
    toll_billing_if.slave bus
);
    logic        cobrar_prev_q;
    logic [13:0] rev_q, rev_d, cnt_q, cnt_d, err_q, err_d, fare_q, fare_d;
    logic        led_q;
    logic [13:0] sel_prev_q, sel_val;
    logic [1:0]  dsel_prev_q;
    logic        pending_q, pending_d;
    disp_state_e state_q, state_d;
    logic [3:0][0:6] hex_q, hex_d;

    logic        charge, fare_ok, changed;
    logic [13:0] fare_lut;
    logic        conv_start, conv_busy, conv_done;
    logic [15:0] bcd;

    assign charge = bus.cobrar & ~cobrar_prev_q;

    always_comb begin
        fare_lut = '0;
        fare_ok  = 1'b1;
        case (bus.automovel)
            CLS_C1:  fare_lut = FARE_C1;
            CLS_C2:  fare_lut = FARE_C2;
            CLS_C3:  fare_lut = FARE_C3;
            CLS_C4:  fare_lut = FARE_C4;
            default: fare_ok  = 1'b0;
        endcase
    end

    always_comb begin
        rev_d  = rev_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        fare_d = fare_q;
        if (bus.clear) begin
            rev_d  = '0;
            cnt_d  = '0;
            err_d  = '0;
            fare_d = '0;
        end else if (charge) begin
            if (fare_ok) begin
                rev_d  = sat_add(rev_q, fare_lut, SAT_MAX);
                cnt_d  = sat_add(cnt_q, 14'd1, SAT_MAX);
                fare_d = fare_lut;
            end else begin
                err_d  = sat_add(err_q, 14'd1, SAT_MAX);
            end
        end
    end

    always_comb begin
        sel_val = rev_q;
        unique case (bus.disp_sel)
            DSP_REV:  sel_val = rev_q;
            DSP_CNT:  sel_val = cnt_q;
            DSP_FARE: sel_val = fare_q;
            DSP_ERR:  sel_val = err_q;
        endcase
    end

    assign changed = (sel_val != sel_prev_q) || (bus.disp_sel != dsel_prev_q);

    // A change seen during a run only re-arms pending; the run itself always completes.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | changed;
        hex_d      = hex_q;
        conv_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q && !conv_busy) begin
                    conv_start = 1'b1;
                    pending_d  = changed;
                    state_d    = StConv;
                end
            end
            StConv: begin
                if (conv_done) state_d = StLatch;
            end
            StLatch: begin
                hex_d[3] = (bcd[15:12] == 4'd0) ? SEG_BLANK : seg_digit(bcd[15:12]);
                hex_d[2] = (bcd[15:8] == 8'd0)  ? SEG_BLANK : seg_digit(bcd[11:8]);
                hex_d[1] = (bcd[15:4] == 12'd0) ? SEG_BLANK : seg_digit(bcd[7:4]);
                hex_d[0] = seg_digit(bcd[3:0]);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clock   (clock),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (sel_val),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cobrar_prev_q <= 1'b1;
            rev_q         <= '0;
            cnt_q         <= '0;
            err_q         <= '0;
            fare_q        <= '0;
            led_q         <= 1'b0;
            sel_prev_q    <= '0;
            dsel_prev_q   <= '0;
            pending_q     <= 1'b1;
            state_q       <= StIdle;
            hex_q         <= {4{SEG_BLANK}};
        end else begin
            cobrar_prev_q <= bus.cobrar;
            rev_q         <= rev_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            fare_q        <= fare_d;
            led_q         <= (err_q != 14'd0);
            sel_prev_q    <= sel_val;
            dsel_prev_q   <= bus.disp_sel;
            pending_q     <= pending_d;
            state_q       <= state_d;
            hex_q         <= hex_d;
        end
    end

    assign bus.HEX3     = hex_q[3];
    assign bus.HEX2     = hex_q[2];
    assign bus.HEX1     = hex_q[1];
    assign bus.HEX0     = hex_q[0];
    assign bus.LEDR_err = led_q;
    assign bus.busy     = (state_q == StConv);
endmodule

// File: tb/tb_toll_billing.sv
// Self-checking bench for toll_billing: a reference model of the totals feeds a queue of
// expected display patterns that are compared once the display has had time to settle.
module tb_toll_billing;
    logic clock = 1'b0;
    logic reset;

    toll_billing_if bus ();

    toll_billing dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int m_rev, m_cnt, m_err, m_fare;

    typedef struct {
        string      name;
        logic [0:6] h3, h2, h1, h0;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] code;
        int         fare;
        logic [1:0] sel;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [0:6] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int sel_val(input logic [1:0] s);
        case (s)
            2'b00:   return m_rev;
            2'b01:   return m_cnt;
            2'b10:   return m_fare;
            default: return m_err;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_rev = 0; m_cnt = 0; m_err = 0; m_fare = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_disp(input string name, input int v);
        exp_t e;
        e.name = name;
        e.h3 = (v >= 1000) ? seg(v / 1000) : 7'b1111111;
        e.h2 = (v >= 100) ? seg((v / 100) % 10) : 7'b1111111;
        e.h1 = (v >= 10) ? seg((v / 10) % 10) : 7'b1111111;
        e.h0 = seg(v % 10);
        sb.push_back(e);
    endtask

    task automatic check_disp();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {e.h3, e.h2, e.h1, e.h0}) begin
            n_bad++;
            $display("FAIL %s: HEX3..0 got %b_%b_%b_%b expected %b_%b_%b_%b", e.name,
                     bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0, e.h3, e.h2, e.h1, e.h0);
        end
    endtask

    task automatic show(input string name, input logic [1:0] sel);
        bus.disp_sel = sel;
        expect_disp(name, sel_val(sel));
        repeat (40) tick();
        check_disp();
    endtask

    task automatic charge(input logic [3:0] code, input int fare, input int hold);
        bus.cobrar = 1'b0;
        tick();
        bus.automovel = code;
        bus.cobrar    = 1'b1;
        if (fare > 0) begin
            m_rev  = sat(m_rev + fare);
            m_cnt  = sat(m_cnt + 1);
            m_fare = fare;
        end else begin
            m_err = sat(m_err + 1);
        end
        repeat (hold) tick();
        bus.cobrar = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        int w;

        vecs[0] = '{code: 4'b1000, fare: 5,  sel: 2'b00};
        vecs[1] = '{code: 4'b0000, fare: 0,  sel: 2'b11};
        vecs[2] = '{code: 4'b1110, fare: 15, sel: 2'b10};
        vecs[3] = '{code: 4'b1010, fare: 0,  sel: 2'b11};
        vecs[4] = '{code: 4'b0111, fare: 0,  sel: 2'b01};
        vecs[5] = '{code: 4'b1111, fare: 20, sel: 2'b00};

        bus.automovel = 4'b0000;
        bus.cobrar    = 1'b0;
        bus.clear     = 1'b0;
        bus.disp_sel  = 2'b00;
        reset         = 1'b1;
        model_reset();
        repeat (2) tick();
        check("rst_hex3", int'(bus.HEX3), int'(7'b1111111));
        check("rst_hex0", int'(bus.HEX0), int'(7'b1111111));
        check("rst_led", int'(bus.LEDR_err), 0);
        check("rst_busy", int'(bus.busy), 0);

        reset = 1'b0;
        expect_disp("rst_zero", 0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.busy) busy_cycles++;
        end
        check("busy_len", busy_cycles, 14);
        check_disp();

        charge(4'b1100, 10, 20);
        show("rev_10", 2'b00);

        // Idle display: new source must appear on exactly the 17th edge.
        bus.disp_sel = 2'b01;
        expect_disp("cnt_1_lat17", m_cnt);
        repeat (16) tick();
        check("lat16_hold", int'(bus.HEX1), int'(seg(1)));
        tick();
        check_disp();

        charge(4'b1111, 20, 3);
        show("rev_30", 2'b00);
        show("cnt_2", 2'b01);

        bus.cobrar = 1'b0;
        tick();
        bus.automovel = 4'b0100;
        bus.cobrar    = 1'b1;
        m_err         = m_err + 1;
        tick();
        check("led_lat0", int'(bus.LEDR_err), 0);
        tick();
        check("led_on", int'(bus.LEDR_err), 1);
        bus.cobrar = 1'b0;
        tick();
        show("err_1", 2'b11);
        show("rev_keep_30", 2'b00);

        foreach (vecs[i]) begin
            charge(vecs[i].code, vecs[i].fare, 2);
            show($sformatf("vec%0d", i), vecs[i].sel);
        end
        show("fare_last", 2'b10);

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_reset();
        for (int i = 0; i < 499; i++) charge(4'b1111, 20, 1);
        charge(4'b1110, 15, 1);
        show("rev_9995", 2'b00);
        charge(4'b1111, 20, 1);
        show("rev_sat", 2'b00);
        charge(4'b1111, 20, 1);
        show("rev_nowrap", 2'b00);
        show("cnt_502", 2'b01);

        bus.automovel = 4'b1000;
        bus.cobrar    = 1'b1;
        reset         = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        repeat (5) tick();
        show("cnt_after_rst", 2'b01);
        charge(4'b1000, 5, 3);
        show("cnt_one", 2'b01);
        show("rev_5", 2'b00);

        charge(4'b0000, 0, 2);
        show("err_pre_clr", 2'b11);
        check("led_pre_clr", int'(bus.LEDR_err), 1);
        bus.cobrar = 1'b0;
        tick();
        bus.clear = 1'b1;
        tick();
        bus.automovel = 4'b1100;
        bus.cobrar    = 1'b1;
        repeat (2) tick();
        bus.clear = 1'b0;
        model_reset();
        repeat (5) tick();
        bus.cobrar = 1'b0;
        tick();
        show("clr_err", 2'b11);
        check("clr_led", int'(bus.LEDR_err), 0);
        show("clr_rev", 2'b00);
        show("clr_cnt", 2'b01);
        show("clr_fare", 2'b10);

        charge(4'b1111, 20, 2);
        show("mid_rev", 2'b00);
        bus.disp_sel = 2'b01;
        w = 0;
        while (!bus.busy && w < 40) begin
            tick();
            w++;
        end
        check("busy_seen", int'(bus.busy), 1);
        repeat (3) tick();
        bus.disp_sel = 2'b11;
        expect_disp("mid_newest", m_err);
        repeat (33) tick();
        check_disp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
